// File: rtl/dcj11_pkg.sv
// dcj11_pkg: shared constants and types for the DCJ11 DAL bus responder.
// AIO cycle codes, bus-status codes, FSM states and cycle classification.
package dcj11_pkg;

    // AIO codes presented by the DCJ11 with the address
    localparam logic [3:0] AIO_RD_LO   = 4'b1000;
    localparam logic [3:0] AIO_RD_HI   = 4'b1110;
    localparam logic [3:0] AIO_WR_WORD = 4'b0011;
    localparam logic [3:0] AIO_WR_BYTE = 4'b0101;
    localparam logic [3:0] AIO_NOP     = 4'b1111;

    // Bus-status codes, latched with the address
    localparam logic [1:0] BS_MEM      = 2'b00;
    localparam logic [1:0] BS_SYSREG   = 2'b01;
    localparam logic [1:0] BS_IOPAGE   = 2'b10;
    localparam logic [1:0] BS_INTERNAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_RD_REQ,
        ST_RD_DRIVE,
        ST_WR_WAIT,
        ST_WR_REQ,
        ST_END
    } state_t;

    typedef enum logic [1:0] {
        CYC_NONE,
        CYC_READ,
        CYC_WR_WORD,
        CYC_WR_BYTE
    } cyc_t;

    // Map an AIO code to the kind of bus cycle it starts
    function automatic cyc_t classify(input logic [3:0] aio);
        cyc_t c;
        if ((aio >= AIO_RD_LO) && (aio <= AIO_RD_HI)) begin
            c = CYC_READ;
        end else if (aio == AIO_WR_WORD) begin
            c = CYC_WR_WORD;
        end else if (aio == AIO_WR_BYTE) begin
            c = CYC_WR_BYTE;
        end else begin
            c = CYC_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/dcj11_sync.sv
// dcj11_sync: STAGES-deep synchronizer for one active-low DCJ11 strobe.
// The level output is the last stage; fall/rise are registered so they
// assert on the same clock the level output changes. STAGES must be >= 2.
module dcj11_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall,
    output logic rise
);

    logic [STAGES-1:0] chain;

    // Shift the pin through the chain; strobes idle high out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{1'b1}};
            fall  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            fall  <= chain[STAGES-1] & ~chain[STAGES-2];
            rise  <= ~chain[STAGES-1] & chain[STAGES-2];
        end
    end

    assign level = chain[STAGES-1];

endmodule

// File: rtl/dcj11_bus_responder.sv
// dcj11_bus_responder: bus-slave end of the DCJ11 DAL interface.
// Claims cycles inside the ADDR_BASE/ADDR_MASK window and forwards them to a
// req/ack local memory port. Optional mem_ack watchdog: DCJ11_RESP_TIMEOUT_EN.
module dcj11_bus_responder
    import dcj11_pkg::*;
#(
    parameter logic [21:0] ADDR_BASE   = 22'o17000000,
    parameter logic [21:0] ADDR_MASK   = 22'o17000000,
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  aio,
    input  logic [1:0]  bs,
    input  logic [21:0] dal_in,
    input  logic        ale_n,
    input  logic        strb_n,
    input  logic        bufctl_n,
    input  logic        sctl_n,
    input  logic        abort_n,
    output logic [15:0] dal_out,
    output logic        dal_oe,
    output logic        dir,
    output logic        mem_req,
    output logic        mem_we,
    output logic [21:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    logic ale_lvl, ale_fall, ale_rise;
    logic strb_lvl, strb_fall, strb_rise;
    logic buf_lvl, buf_fall, buf_rise;
    logic sctl_lvl, sctl_fall, sctl_rise;
    logic abort_lvl, abort_fall, abort_rise;

    dcj11_sync #(.STAGES(SYNC_STAGES)) u_sync_ale (
        .clk(clk), .rst(rst), .din(ale_n), .level(ale_lvl), .fall(ale_fall), .rise(ale_rise));
    dcj11_sync #(.STAGES(SYNC_STAGES)) u_sync_strb (
        .clk(clk), .rst(rst), .din(strb_n), .level(strb_lvl), .fall(strb_fall), .rise(strb_rise));
    dcj11_sync #(.STAGES(SYNC_STAGES)) u_sync_bufctl (
        .clk(clk), .rst(rst), .din(bufctl_n), .level(buf_lvl), .fall(buf_fall), .rise(buf_rise));
    dcj11_sync #(.STAGES(SYNC_STAGES)) u_sync_sctl (
        .clk(clk), .rst(rst), .din(sctl_n), .level(sctl_lvl), .fall(sctl_fall), .rise(sctl_rise));
    dcj11_sync #(.STAGES(SYNC_STAGES)) u_sync_abort (
        .clk(clk), .rst(rst), .din(abort_n), .level(abort_lvl), .fall(abort_fall), .rise(abort_rise));

    // Only levels and the ALE fall edge steer the FSM; bus status is latched
    // with the address but does not take part in claiming a cycle.
    logic unused_inputs;

    logic [21:0] dal_q;
    logic [3:0]  aio_q, aio_l;
    logic [1:0]  bs_q, bs_l;
    state_t      state, state_d;
    cyc_t        cyc;
    logic        claimed, abort_hit, timeout;
    logic [21:0] addr_d;
    logic [3:0]  aio_d;
    logic [1:0]  bs_d, be_d;
    logic [15:0] wdata_d, rdata_d;
    logic        err_d;

    assign unused_inputs = ^{ale_rise, strb_fall, strb_rise, buf_fall, buf_rise,
                             sctl_fall, sctl_rise, abort_fall, abort_rise, bs_l};

    assign cyc     = classify(aio_l);
    assign claimed = ((mem_addr & ADDR_MASK) == ADDR_BASE);
    // Abort acts once per cycle: END is where an abort lands, so it is not re-armed there
    assign abort_hit = !abort_lvl && (state != ST_IDLE) && (state != ST_END);
    assign dir = dal_oe;

`ifdef DCJ11_RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    assign timeout = ((state == ST_RD_REQ) || (state == ST_WR_REQ)) &&
                     (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Count clocks spent waiting in a request state without leaving it
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= {TW{1'b0}};
        end else if (((state == ST_RD_REQ) || (state == ST_WR_REQ)) && (state_d == state)) begin
            tmo_cnt <= tmo_cnt + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt <= {TW{1'b0}};
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC == 0);
    assign timeout    = 1'b0;
`endif

    // Register the raw DAL/AIO/BS pins one stage; they are only used under a strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            dal_q <= 22'd0;
            aio_q <= 4'd0;
            bs_q  <= 2'd0;
        end else begin
            dal_q <= dal_in;
            aio_q <= aio;
            bs_q  <= bs;
        end
    end

    // Next-state and next-value logic for the cycle FSM
    always_comb begin
        state_d = state;
        addr_d  = mem_addr;
        aio_d   = aio_l;
        bs_d    = bs_l;
        be_d    = mem_be;
        wdata_d = mem_wdata;
        rdata_d = dal_out;
        err_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ale_fall) begin
                    addr_d  = dal_q;
                    aio_d   = aio_q;
                    bs_d    = bs_q;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (claimed && (cyc == CYC_READ)) begin
                    be_d    = 2'b11;
                    state_d = ST_RD_REQ;
                end else if (claimed && ((cyc == CYC_WR_WORD) || (cyc == CYC_WR_BYTE))) begin
                    state_d = ST_WR_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RD_DRIVE;
                end else if (timeout) begin
                    rdata_d = 16'o177777;
                    err_d   = 1'b1;
                    state_d = ST_RD_DRIVE;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_DRIVE: begin
                if (buf_lvl) begin
                    state_d = ST_END;
                end else begin
                    state_d = ST_RD_DRIVE;
                end
            end
            ST_WR_WAIT: begin
                if (!sctl_lvl) begin
                    wdata_d = dal_q[15:0];
                    if (cyc == CYC_WR_BYTE) begin
                        be_d = mem_addr[0] ? 2'b10 : 2'b01;
                    end else begin
                        be_d = 2'b11;
                    end
                    state_d = ST_WR_REQ;
                end else begin
                    state_d = ST_WR_WAIT;
                end
            end
            ST_WR_REQ: begin
                if (mem_ack) begin
                    state_d = ST_END;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_END;
                end else begin
                    state_d = ST_WR_REQ;
                end
            end
            ST_END: begin
                if (strb_lvl && ale_lvl) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_END;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort overrides everything, including a same-clock mem_ack
        if (abort_hit) begin
            rdata_d = dal_out;
            err_d   = 1'b1;
            state_d = ST_END;
        end else begin
            err_d = err_d;
        end
    end

    // State register and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_addr  <= 22'd0;
            aio_l     <= 4'd0;
            bs_l      <= 2'd0;
            mem_be    <= 2'b00;
            mem_wdata <= 16'd0;
            dal_out   <= 16'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            dal_oe    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            mem_addr  <= addr_d;
            aio_l     <= aio_d;
            bs_l      <= bs_d;
            mem_be    <= be_d;
            mem_wdata <= wdata_d;
            dal_out   <= rdata_d;
            mem_req   <= (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
            mem_we    <= (state_d == ST_WR_REQ);
            dal_oe    <= (state_d == ST_RD_DRIVE) && !buf_lvl;
            busy      <= (state_d != ST_IDLE);
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_dcj11_bus_responder.sv
// tb_dcj11_bus_responder: directed test of the DCJ11 bus responder with
// SYNC_STAGES=2. The timeout scenario is included when DCJ11_RESP_TIMEOUT_EN
// is defined (DUT built with TIMEOUT_CYC=8).
module tb_dcj11_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  aio;
    logic [1:0]  bs;
    logic [21:0] dal_in;
    logic        ale_n, strb_n, bufctl_n, sctl_n, abort_n;
    logic [15:0] dal_out;
    logic        dal_oe, dir, mem_req, mem_we;
    logic [21:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        busy, err;

    int vectors = 0;
    int fails   = 0;
    int err_cnt, oe_seen, req_cnt;

    always #5 clk = ~clk;

    dcj11_bus_responder #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .aio(aio), .bs(bs), .dal_in(dal_in),
        .ale_n(ale_n), .strb_n(strb_n), .bufctl_n(bufctl_n), .sctl_n(sctl_n),
        .abort_n(abort_n), .dal_out(dal_out), .dal_oe(dal_oe), .dir(dir),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .err(err));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pins_idle();
        aio = 4'b1111; bs = 2'b00; dal_in = 22'd0;
        ale_n = 1'b1; strb_n = 1'b1; bufctl_n = 1'b1; sctl_n = 1'b1; abort_n = 1'b1;
        mem_ack = 1'b0; mem_rdata = 16'd0;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        pins_idle();
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_dal_oe", 32'(dal_oe), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_dal_out", 32'(dal_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Word read, ack after 3 clocks
        dal_in = 22'o17000100; aio = 4'b1001; ale_n = 1'b0; strb_n = 1'b0; bufctl_n = 1'b0;
        step(3);
        check("rd_addr_latched", 32'(mem_addr), 32'o17000100);
        check("rd_busy", 32'(busy), 32'd1);
        check("rd_no_req_in_decode", 32'(mem_req), 32'd0);
        step(1);
        check("rd_req", 32'(mem_req), 32'd1);
        check("rd_we", 32'(mem_we), 32'd0);
        check("rd_be", 32'(mem_be), 32'b11);
        step(2);
        check("rd_req_held", 32'(mem_req), 32'd1);
        check("rd_oe_before_ack", 32'(dal_oe), 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'o123456;
        step(1);
        mem_ack = 1'b0; mem_rdata = 16'd0;
        check("rd_dal_out", 32'(dal_out), 32'o123456);
        check("rd_oe", 32'(dal_oe), 32'd1);
        check("rd_dir", 32'(dir), 32'd1);
        check("rd_req_dropped", 32'(mem_req), 32'd0);
        step(2);
        check("rd_oe_while_bufctl_low", 32'(dal_oe), 32'd1);
        bufctl_n = 1'b1;
        step(2);
        check("rd_oe_before_turnaround", 32'(dal_oe), 32'd1);
        step(1);
        check("rd_oe_off_at_3", 32'(dal_oe), 32'd0);
        check("rd_dir_off", 32'(dir), 32'd0);
        check("rd_busy_in_end", 32'(busy), 32'd1);
        ale_n = 1'b1; strb_n = 1'b1;
        step(3);
        check("rd_back_idle", 32'(busy), 32'd0);

        // Byte write, odd address
        dal_in = 22'o17000101; aio = 4'b0101; ale_n = 1'b0; strb_n = 1'b0;
        step(4);
        check("bw_wait_no_req", 32'(mem_req), 32'd0);
        dal_in = 22'o000377; sctl_n = 1'b0;
        step(2);
        check("bw_no_req_before_sctl", 32'(mem_req), 32'd0);
        step(1);
        check("bw_req", 32'(mem_req), 32'd1);
        check("bw_we", 32'(mem_we), 32'd1);
        check("bw_be_odd", 32'(mem_be), 32'b10);
        check("bw_wdata", 32'(mem_wdata), 32'o000377);
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        check("bw_req_dropped", 32'(mem_req), 32'd0);
        check("bw_we_dropped", 32'(mem_we), 32'd0);
        ale_n = 1'b1; strb_n = 1'b1; sctl_n = 1'b1;
        step(3);
        check("bw_back_idle", 32'(busy), 32'd0);

        // Word write, even address
        dal_in = 22'o17000102; aio = 4'b0011; ale_n = 1'b0; strb_n = 1'b0;
        step(4);
        dal_in = 22'o054321; sctl_n = 1'b0;
        step(3);
        check("ww_be", 32'(mem_be), 32'b11);
        check("ww_wdata", 32'(mem_wdata), 32'o054321);
        check("ww_we", 32'(mem_we), 32'd1);
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        ale_n = 1'b1; strb_n = 1'b1; sctl_n = 1'b1;
        step(3);
        check("ww_back_idle", 32'(busy), 32'd0);

        // Out-of-window read
        dal_in = 22'o00001000; aio = 4'b1001; ale_n = 1'b0; strb_n = 1'b0; bufctl_n = 1'b0;
        step(3);
        check("oow_busy_decode", 32'(busy), 32'd1);
        check("oow_addr", 32'(mem_addr), 32'o00001000);
        req_cnt = 0; oe_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            req_cnt += int'(mem_req);
            oe_seen += int'(dal_oe);
        end
        check("oow_busy_fell", 32'(busy), 32'd0);
        check("oow_no_req", 32'(req_cnt), 32'd0);
        check("oow_no_oe", 32'(oe_seen), 32'd0);
        pins_idle();
        step(3);

        // In-window non-bus code is ignored
        dal_in = 22'o17000500; aio = 4'b1111; ale_n = 1'b0;
        step(4);
        check("nop_busy", 32'(busy), 32'd0);
        check("nop_no_req", 32'(mem_req), 32'd0);
        pins_idle();
        step(3);

        // Abort during RD_REQ; ack arrives in the same clock the abort lands
        dal_in = 22'o17000200; aio = 4'b1000; ale_n = 1'b0; strb_n = 1'b0; bufctl_n = 1'b0;
        step(4);
        check("ab_req", 32'(mem_req), 32'd1);
        abort_n = 1'b0;
        err_cnt = 0; oe_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            err_cnt += int'(err);
            oe_seen += int'(dal_oe);
            mem_ack   = (i == 1);
            mem_rdata = (i == 1) ? 16'o111111 : 16'd0;
        end
        check("ab_err_once", 32'(err_cnt), 32'd1);
        check("ab_no_oe", 32'(oe_seen), 32'd0);
        check("ab_req_dropped", 32'(mem_req), 32'd0);
        check("ab_late_ack_ignored", 32'(dal_out), 32'o123456);
        pins_idle();
        step(4);
        check("ab_back_idle", 32'(busy), 32'd0);

`ifdef DCJ11_RESP_TIMEOUT_EN
        // Read with no ack: watchdog of 8 clocks
        dal_in = 22'o17000400; aio = 4'b1001; ale_n = 1'b0; strb_n = 1'b0; bufctl_n = 1'b0;
        step(4);
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (err == 1'b0) begin
                req_cnt += int'(mem_req);
                step(1);
            end
        end
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_req_clocks", 32'(req_cnt), 32'd8);
        check("tmo_dal_out", 32'(dal_out), 32'o177777);
        check("tmo_oe", 32'(dal_oe), 32'd1);
        check("tmo_req_dropped", 32'(mem_req), 32'd0);
        pins_idle();
        step(4);
`endif

        // Reset while driving read data
        dal_in = 22'o17000300; aio = 4'b1001; ale_n = 1'b0; strb_n = 1'b0; bufctl_n = 1'b0;
        step(4);
        mem_ack = 1'b1; mem_rdata = 16'o070707;
        step(1);
        mem_ack = 1'b0;
        check("mr_oe_before", 32'(dal_oe), 32'd1);
        rst = 1'b1;
        pins_idle();
        step(1);
        check("mr_oe", 32'(dal_oe), 32'd0);
        check("mr_dir", 32'(dir), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step(3);
        check("mr_stays_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
